a2d_scan_intf: RTL and testbench



---
 rtl/a2d_pkg.sv | 46 ++++
 rtl/spi_frame_mstr.sv | 83 ++++++++
 rtl/a2d_scan_intf.sv | 138 +++++++++++++
 tb/tb_a2d_scan_intf.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/a2d_pkg.sv
// rtl/a2d_pkg.sv - shared types and helpers for the A2D scan interface
package a2d_pkg;

    localparam int CH_FIELD_W = 3;
    localparam int NUM_CH_MAX = 1 << CH_FIELD_W;
    localparam int CMD_W_MAX  = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FRAME1 = 3'd1,
        GAP    = 3'd2,
        FRAME2 = 3'd3,
        DONE   = 3'd4
    } state_t;

    // Command word {2'b00, ch, zeros}, left-justified to frame_w bits.
    function automatic logic [CMD_W_MAX-1:0] make_cmd(input logic [CH_FIELD_W-1:0] ch,
                                                      input int frame_w);
        logic [CMD_W_MAX-1:0] word;
        word = {{(CMD_W_MAX-CH_FIELD_W){1'b0}}, ch};
        return word << (frame_w - 2 - CH_FIELD_W);
    endfunction

    // First channel set in mask after ptr, wrapping num_ch-1 -> 0.
    // Returns ptr itself if ptr is the only masked channel.
    function automatic logic [CH_FIELD_W-1:0] next_masked(input logic [CH_FIELD_W-1:0] ptr,
                                                          input logic [NUM_CH_MAX-1:0] mask,
                                                          input int num_ch);
        logic [CH_FIELD_W-1:0] nxt;
        logic [CH_FIELD_W-1:0] cand;
        logic                  found;
        nxt   = ptr;
        found = 1'b0;
        for (int i = 1; i <= NUM_CH_MAX; i++) begin
            if (i <= num_ch) begin
                cand = CH_FIELD_W'((int'(ptr) + i) % num_ch);
                if (!found && mask[cand]) begin
                    nxt   = cand;
                    found = 1'b1;
                end
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/spi_frame_mstr.sv
// rtl/spi_frame_mstr.sv - single clock-divided SPI frame: command out, read data in
module spi_frame_mstr #(
    parameter int FRAME_W  = 16,
    parameter int SCLK_DIV = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wrt,
    input  logic [FRAME_W-1:0] cmd,
    input  logic               MISO,
    output logic               done,
    output logic [FRAME_W-1:0] rd_data,
    output logic               SS_n,
    output logic               SCLK,
    output logic               MOSI
);

    localparam int HALF   = SCLK_DIV / 2;
    localparam int DIV_W  = $clog2(HALF);
    localparam int EDGES  = 2 * FRAME_W;
    localparam int EDGE_W = $clog2(EDGES + 1);

    logic               active;
    logic [DIV_W-1:0]   div_cnt;
    logic [EDGE_W-1:0]  edge_cnt;
    logic [FRAME_W-1:0] tx_shift;
    logic [FRAME_W-1:0] rx_shift;
    logic               half_end;
    logic               last_half;

    // A half period ends every HALF clks; the extra final half is the trailing high phase.
    assign half_end  = active && (div_cnt == DIV_W'(HALF - 1));
    assign last_half = (edge_cnt == EDGE_W'(EDGES));
    assign MOSI      = tx_shift[FRAME_W-1];
    assign rd_data   = rx_shift;

    // Frame sequencer: leading high half, FRAME_W low/high periods, then SS_n release.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active   <= 1'b0;
            div_cnt  <= '0;
            edge_cnt <= '0;
            tx_shift <= '0;
            rx_shift <= '0;
            SS_n     <= 1'b1;
            SCLK     <= 1'b1;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!active) begin
                if (wrt) begin
                    active   <= 1'b1;
                    SS_n     <= 1'b0;
                    SCLK     <= 1'b1;
                    div_cnt  <= '0;
                    edge_cnt <= '0;
                    tx_shift <= cmd;
                end
            end else begin
                div_cnt <= half_end ? '0 : div_cnt + 1'b1;
                if (half_end) begin
                    if (last_half) begin
                        active   <= 1'b0;
                        SS_n     <= 1'b1;
                        done     <= 1'b1;
                        tx_shift <= '0;
                    end else begin
                        SCLK     <= ~SCLK;
                        edge_cnt <= edge_cnt + 1'b1;
                        if (SCLK) begin
                            // First fall keeps the MSB already on MOSI since SS_n fell.
                            if (edge_cnt != '0)
                                tx_shift <= {tx_shift[FRAME_W-2:0], 1'b0};
                        end else begin
                            rx_shift <= {rx_shift[FRAME_W-2:0], MISO};
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/a2d_scan_intf.sv
// rtl/a2d_scan_intf.sv - two-frame ADC conversion sequencer with round-robin scan and result bank
module a2d_scan_intf
    import a2d_pkg::*;
#(
    parameter int NUM_CH   = 8,
    parameter int RES_W    = 12,
    parameter int FRAME_W  = 16,
    parameter int SCLK_DIV = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  strt_cnv,
    input  logic [CH_FIELD_W-1:0] chnnl,
    input  logic                  scan_en,
    input  logic [NUM_CH-1:0]     ch_mask,
    input  logic [CH_FIELD_W-1:0] rd_chnl,
    input  logic                  MISO,
    output logic                  a2d_SS_n,
    output logic                  SCLK,
    output logic                  MOSI,
    output logic                  busy,
    output logic                  cnv_cmplt,
    output logic [CH_FIELD_W-1:0] cnv_chnl,
    output logic [RES_W-1:0]      res,
    output logic [RES_W-1:0]      rd_res,
    output logic                  rd_vld
);

    localparam int                  GAP_W    = $clog2(SCLK_DIV);
    localparam logic [CH_FIELD_W:0] NUM_CH_L = (CH_FIELD_W + 1)'(NUM_CH);

    state_t                state;
    logic [CH_FIELD_W-1:0] cur_ch;
    logic [CH_FIELD_W-1:0] scan_ptr;
    logic [GAP_W-1:0]      gap_cnt;
    logic [RES_W-1:0]      bank [NUM_CH_MAX];
    logic [NUM_CH_MAX-1:0] bank_vld;

    logic [NUM_CH_MAX-1:0] mask_ext;
    logic                  ss_ok;
    logic                  scan_ok;
    logic                  launch;
    logic [CH_FIELD_W-1:0] launch_ch;
    logic                  gap_end;
    logic                  spi_wrt;
    logic [FRAME_W-1:0]    spi_cmd;
    logic                  spi_done;
    logic [FRAME_W-1:0]    spi_rd_data;
    logic [RES_W-1:0]      spi_res;

    assign spi_res = RES_W'(spi_rd_data);
    assign rd_res  = bank[rd_chnl];
    assign rd_vld  = bank_vld[rd_chnl];

    // Launch arbitration (single-shot beats scan) and frame-start requests to the SPI engine.
    always_comb begin
        mask_ext  = NUM_CH_MAX'(ch_mask);
        ss_ok     = strt_cnv && ({1'b0, chnnl} < NUM_CH_L);
        scan_ok   = scan_en && (mask_ext != '0);
        launch    = (state == IDLE) && (ss_ok || scan_ok);
        launch_ch = ss_ok ? chnnl : next_masked(scan_ptr, mask_ext, NUM_CH);
        gap_end   = (state == GAP) && (gap_cnt == GAP_W'(SCLK_DIV - 2));
        spi_wrt   = launch || gap_end;
        spi_cmd   = FRAME_W'(make_cmd((state == IDLE) ? launch_ch : cur_ch, FRAME_W));
    end

    spi_frame_mstr #(
        .FRAME_W  (FRAME_W),
        .SCLK_DIV (SCLK_DIV)
    ) u_spi (
        .clk     (clk),
        .rst     (rst),
        .wrt     (spi_wrt),
        .cmd     (spi_cmd),
        .MISO    (MISO),
        .done    (spi_done),
        .rd_data (spi_rd_data),
        .SS_n    (a2d_SS_n),
        .SCLK    (SCLK),
        .MOSI    (MOSI)
    );

    // Conversion FSM: launch, command frame, SS_n gap, read frame, then publish the result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cur_ch    <= '0;
            scan_ptr  <= CH_FIELD_W'(NUM_CH - 1);
            gap_cnt   <= '0;
            busy      <= 1'b0;
            cnv_cmplt <= 1'b0;
            cnv_chnl  <= '0;
            res       <= '0;
            bank_vld  <= '0;
            for (int i = 0; i < NUM_CH_MAX; i++)
                bank[i] <= '0;
        end else begin
            cnv_cmplt <= 1'b0;
            case (state)
                IDLE: begin
                    // Also the cnv_cmplt cycle, so back-to-back scans launch from here.
                    busy <= launch;
                    if (launch) begin
                        state  <= FRAME1;
                        cur_ch <= launch_ch;
                        if (!ss_ok)
                            scan_ptr <= launch_ch;
                    end
                end
                FRAME1: begin
                    if (spi_done) begin
                        state   <= GAP;
                        gap_cnt <= '0;
                    end
                end
                GAP: begin
                    gap_cnt <= gap_cnt + 1'b1;
                    if (gap_end)
                        state <= FRAME2;
                end
                FRAME2: begin
                    if (spi_done)
                        state <= DONE;
                end
                DONE: begin
                    state            <= IDLE;
                    cnv_cmplt        <= 1'b1;
                    cnv_chnl         <= cur_ch;
                    res              <= spi_res;
                    bank[cur_ch]     <= spi_res;
                    bank_vld[cur_ch] <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_a2d_scan_intf.sv
// tb/tb_a2d_scan_intf.sv - directed self-checking bench for a2d_scan_intf
module tb_a2d_scan_intf;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Instance A: defaults
    logic        a_strt, a_scan, a_miso, a_ss_n, a_sclk, a_mosi, a_busy, a_cmplt, a_rd_vld;
    logic [2:0]  a_ch, a_rd, a_cnv_ch;
    logic [7:0]  a_mask;
    logic [11:0] a_res, a_rd_res;

    a2d_scan_intf u_dut_a (
        .clk(clk), .rst(rst), .strt_cnv(a_strt), .chnnl(a_ch), .scan_en(a_scan),
        .ch_mask(a_mask), .rd_chnl(a_rd), .MISO(a_miso), .a2d_SS_n(a_ss_n),
        .SCLK(a_sclk), .MOSI(a_mosi), .busy(a_busy), .cnv_cmplt(a_cmplt),
        .cnv_chnl(a_cnv_ch), .res(a_res), .rd_res(a_rd_res), .rd_vld(a_rd_vld)
    );

    // Instance B: fast SCLK
    logic        b_strt, b_scan, b_miso, b_ss_n, b_sclk, b_mosi, b_busy, b_cmplt, b_rd_vld;
    logic [2:0]  b_ch, b_rd, b_cnv_ch;
    logic [7:0]  b_mask;
    logic [11:0] b_res, b_rd_res;

    a2d_scan_intf #(.SCLK_DIV(4)) u_dut_b (
        .clk(clk), .rst(rst), .strt_cnv(b_strt), .chnnl(b_ch), .scan_en(b_scan),
        .ch_mask(b_mask), .rd_chnl(b_rd), .MISO(b_miso), .a2d_SS_n(b_ss_n),
        .SCLK(b_sclk), .MOSI(b_mosi), .busy(b_busy), .cnv_cmplt(b_cmplt),
        .cnv_chnl(b_cnv_ch), .res(b_res), .rd_res(b_rd_res), .rd_vld(b_rd_vld)
    );

    // Instance C: four channels
    logic        c_strt, c_scan, c_ss_n, c_sclk, c_mosi, c_busy, c_cmplt, c_rd_vld;
    logic [2:0]  c_ch, c_rd, c_cnv_ch;
    logic [3:0]  c_mask;
    logic [11:0] c_res, c_rd_res;

    a2d_scan_intf #(.NUM_CH(4), .SCLK_DIV(4)) u_dut_c (
        .clk(clk), .rst(rst), .strt_cnv(c_strt), .chnnl(c_ch), .scan_en(c_scan),
        .ch_mask(c_mask), .rd_chnl(c_rd), .MISO(1'b0), .a2d_SS_n(c_ss_n),
        .SCLK(c_sclk), .MOSI(c_mosi), .busy(c_busy), .cnv_cmplt(c_cmplt),
        .cnv_chnl(c_cnv_ch), .res(c_res), .rd_res(c_rd_res), .rd_vld(c_rd_vld)
    );

    // ADC model A: answers 0x0A5C when the previous frame commanded ch5, else 0xFFFF
    logic [15:0] a_tx = '0, a_rx = '0, a_prev = '0, a_frm0 = '0, a_frm1 = '0;
    int          a_fall = 0, a_nfrm = 0;
    always @(negedge a_ss_n) begin
        a_tx   = (a_prev[13:11] == 3'd5) ? 16'h0A5C : 16'hFFFF;
        a_fall = 0;
        a_rx   = '0;
    end
    always @(negedge a_sclk) if (!a_ss_n) begin
        if (a_fall != 0) a_tx = {a_tx[14:0], 1'b0};
        a_fall++;
    end
    always @(posedge a_sclk) if (!a_ss_n) a_rx = {a_rx[14:0], a_mosi};
    always @(posedge a_ss_n) begin
        a_prev = a_rx;
        if (a_nfrm == 0) a_frm0 = a_rx;
        else if (a_nfrm == 1) a_frm1 = a_rx;
        a_nfrm++;
    end
    assign a_miso = a_tx[15];

    // ADC model B: answers prev_channel * 0x0111; also counts rising SCLK per frame
    logic [15:0] b_tx = '0, b_rx = '0;
    logic [2:0]  b_prev_ch = '0;
    int          b_fall = 0, b_rise_run = 0, b_rise_last = 0, b_rise_prev = 0;
    always @(negedge b_ss_n) begin
        b_tx   = 16'(b_prev_ch) * 16'h0111;
        b_fall = 0;
        b_rx   = '0;
    end
    always @(negedge b_sclk) if (!b_ss_n) begin
        if (b_fall != 0) b_tx = {b_tx[14:0], 1'b0};
        b_fall++;
    end
    always @(posedge b_sclk) if (!b_ss_n) begin
        b_rx = {b_rx[14:0], b_mosi};
        b_rise_run++;
    end
    always @(posedge b_ss_n) begin
        b_prev_ch   = b_rx[13:11];
        b_rise_prev = b_rise_last;
        b_rise_last = b_rise_run;
        b_rise_run  = 0;
    end
    assign b_miso = b_tx[15];

    // B frame-timing monitor, sampled on the falling clk edge
    int   b_low_run = 0, b_low_last = 0, b_low_prev = 0, b_hi_run = 0, b_gap = 0, b_mosi_viol = 0;
    logic b_pss = 1'b1, b_psclk = 1'b1, b_pmosi = 1'b0;
    always @(negedge clk) begin
        if (!b_ss_n) begin
            if (b_hi_run != 0) begin b_gap = b_hi_run; b_hi_run = 0; end
            b_low_run++;
        end else begin
            if (b_low_run != 0) begin
                b_low_prev = b_low_last; b_low_last = b_low_run; b_low_run = 0;
            end
            b_hi_run++;
        end
        if (!b_ss_n && !b_pss && (b_mosi !== b_pmosi) && !(b_psclk && !b_sclk))
            b_mosi_viol++;
        b_pss = b_ss_n; b_psclk = b_sclk; b_pmosi = b_mosi;
    end

    int c_falls = 0;
    always @(negedge c_ss_n) c_falls++;

    task automatic wait_b(output int cyc);
        cyc = 0;
        while (!b_cmplt && cyc < 400) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    int          cyc;
    logic        seen;
    logic [2:0]  exp_ch [7] = '{3'd0, 3'd2, 3'd7, 3'd0, 3'd2, 3'd3, 3'd7};

    initial begin
        rst = 1'b1;
        a_strt = 0; a_scan = 0; a_ch = 0; a_rd = 0; a_mask = 0;
        b_strt = 0; b_scan = 0; b_ch = 0; b_rd = 0; b_mask = 0;
        c_strt = 0; c_scan = 0; c_ch = 0; c_rd = 0; c_mask = 0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // reset state
        check("rst_ss_n", a_ss_n, 1); check("rst_sclk", a_sclk, 1);
        check("rst_mosi", a_mosi, 0); check("rst_busy", a_busy, 0);
        check("rst_cmplt", a_cmplt, 0); check("rst_chnl", a_cnv_ch, 0);
        check("rst_res", a_res, 0); check("rst_rd_vld", a_rd_vld, 0);

        // single-shot ch5 on defaults: latency and data
        a_nfrm = 0;
        a_strt = 1; a_ch = 5;
        @(negedge clk);
        a_strt = 0; cyc = 0;
        while (!a_cmplt && cyc < 1200) begin @(negedge clk); cyc++; end
        check("a_latency", cyc, 1090);
        check("a_res", a_res, 12'hA5C);
        check("a_chnl", a_cnv_ch, 5);
        check("a_busy_at_cmplt", a_busy, 1);
        check("a_nframes", a_nfrm, 2);
        check("a_mosi_frm1", a_frm0, 16'h2800);
        check("a_mosi_frm2", a_frm1, 16'h2800);
        a_rd = 5; #1;
        check("a_rd_res5", a_rd_res, 12'hA5C); check("a_rd_vld5", a_rd_vld, 1);
        a_rd = 4; #1;
        check("a_rd_vld4", a_rd_vld, 0);
        @(negedge clk);
        check("a_cmplt_pulse", a_cmplt, 0); check("a_busy_after", a_busy, 0);

        // reset 100 clks into FRAME1
        a_strt = 1; a_ch = 1;
        @(negedge clk);
        a_strt = 0;
        repeat (99) @(negedge clk);
        check("mid_ss_low", a_ss_n, 0); check("mid_busy", a_busy, 1);
        rst = 1'b1; #1;
        check("mid_rst_ss_n", a_ss_n, 1); check("mid_rst_sclk", a_sclk, 1);
        check("mid_rst_mosi", a_mosi, 0); check("mid_rst_busy", a_busy, 0);
        for (int i = 0; i < 8; i++) begin
            a_rd = 3'(i); #1;
            check($sformatf("mid_rst_vld%0d", i), a_rd_vld, 0);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // fast instance: frame timing, single-shot ch2 (scan pointer must stay put)
        b_strt = 1; b_ch = 2;
        @(negedge clk);
        b_strt = 0;
        wait_b(cyc);
        check("b_latency", cyc, 138);
        check("b_res", b_res, 12'h222);
        check("b_ss_low1", b_low_prev, 66); check("b_ss_low2", b_low_last, 66);
        check("b_gap", b_gap, 4);
        check("b_rises1", b_rise_prev, 16); check("b_rises2", b_rise_last, 16);
        check("b_mosi_stable", b_mosi_viol, 0);
        @(negedge clk);

        // scan over mask 1000_0101 with an ignored and an accepted single-shot ch3
        b_mask = 8'b1000_0101; b_scan = 1;
        for (int i = 0; i < 7; i++) begin
            wait_b(cyc);
            check($sformatf("scan%0d_cmplt", i), b_cmplt, 1);
            check($sformatf("scan%0d_chnl", i), b_cnv_ch, exp_ch[i]);
            check($sformatf("scan%0d_res", i), b_res, 12'(exp_ch[i]) * 12'h111);
            check($sformatf("scan%0d_idle_ss", i), b_ss_n, 1);
            if (i == 4) begin b_strt = 1; b_ch = 3; end
            if (i == 6) b_scan = 0;
            @(negedge clk);
            b_strt = 0;
            check($sformatf("scan%0d_next_ss", i), b_ss_n, (i == 6) ? 1 : 0);
            if (i == 6) check("scan_stop_busy", b_busy, 0);
            if (i == 0) begin
                repeat (20) @(negedge clk);
                b_strt = 1; b_ch = 3;
                @(negedge clk);
                b_strt = 0;
            end
        end
        b_rd = 7; #1;
        check("b_bank7", b_rd_res, 12'h777); check("b_vld7", b_rd_vld, 1);
        b_rd = 3; #1;
        check("b_bank3", b_rd_res, 12'h333);
        b_rd = 1; #1;
        check("b_vld1", b_rd_vld, 0);

        // four-channel instance: out-of-range request and empty mask do nothing
        c_strt = 1; c_ch = 6;
        @(negedge clk);
        c_strt = 0; seen = 0;
        repeat (40) begin @(negedge clk); seen |= c_busy; end
        check("c_oor_busy", seen, 0); check("c_oor_ss", c_falls, 0);
        c_scan = 1; c_mask = 4'b0000; seen = 0;
        repeat (40) begin @(negedge clk); seen |= c_busy; end
        check("c_nomask_busy", seen, 0); check("c_nomask_ss", c_falls, 0);
        c_mask = 4'b0100;
        @(negedge clk);
        check("c_scan_busy", c_busy, 1); check("c_scan_ss", c_ss_n, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
